// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from per-bit JK cells.
// The excitation (j_o/k_o) is derived from the requested next state and exported.
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             c,
    input  logic             rs,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_params
        $error("jk_mod_counter: need WIDTH>=2 and 2<=MODULUS<=2**WIDTH");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_c, k_c;
    logic             d_ok, in_range, at_max, at_zero;

    assign d_ok     = {1'b0, d} < MOD_W;
    assign in_range = {1'b0, q_q} < MOD_W;
    assign at_max   = (q_q == MAX_V);
    assign at_zero  = (q_q == '0);

    // Requested next state; out-of-range states recover to 0 (up) or MODULUS-1 (down).
    always_comb begin
        nxt = q_q;
        if (ld) begin
            nxt = d_ok ? d : '0;
        end else if (en) begin
            if (up) begin
                nxt = (at_max || !in_range) ? '0 : q_q + WIDTH'(1);
            end else begin
                nxt = (at_zero || !in_range) ? MAX_V : q_q - WIDTH'(1);
            end
        end
    end

    assign j_c = ~q_q & nxt;
    assign k_c = q_q & ~nxt;

    // JK characteristic per bit: set on J, clear on K, toggle on both, else hold.
    assign q_d   = (j_c & ~q_q) | (~k_c & q_q);
    assign err_d = ld & ~d_ok;

    always_ff @(posedge c or negedge rs) begin
        if (!rs) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign q   = q_q;
    assign qb  = ~q_q;
    assign err = err_q;
    assign j_o = j_c;
    assign k_o = k_c;
    assign tc  = en & ~ld & ((up & at_max) | (~up & at_zero));

endmodule
